sparse_gather_pipe: RTL and testbench

- Pipelined, parametrised gather multiplexer for the unstructured-sparsity datapath.
- Each of NUM_OUT output lanes picks one of NUM_IN input elements by index. A per-lane mask zeroes pruned lanes.
- Sits between the sparse operand buffer and the MAC array, with valid/ready flow control on both sides.
- Two register stages, full throughput of one transfer per cycle, backpressure-safe. Out-of-range indices are detected and reported.

---
 rtl/sparse_gather_pipe.sv | 138 +++++++++++++
 tb/tb_sparse_gather_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_gather_pipe.sv
// Two-stage gather pipeline. Each output lane selects one input element by index.
// Per-lane masking, valid/ready flow control and a sticky out-of-range flag are included.
module sparse_gather_pipe #(
    parameter int DW_DATA = 8,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int SEL_IN  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW_DATA*NUM_IN-1:0]  in_data,
    input  logic [SEL_IN*NUM_OUT-1:0]  in_sel,
    input  logic [NUM_OUT-1:0]         in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW_DATA*NUM_OUT-1:0] out_data,
    output logic [NUM_OUT-1:0]         out_mask,
    output logic                       err_oob,
    input  logic                       err_clr
);

    generate
        if ((1 << SEL_IN) < NUM_IN) begin : g_sel_width_check
            $error("sparse_gather_pipe: SEL_IN too narrow to address NUM_IN elements");
        end
    endgenerate

    // Stage A: raw operands
    logic                       a_valid_q, a_valid_d;
    logic [DW_DATA*NUM_IN-1:0]  a_data_q,  a_data_d;
    logic [SEL_IN*NUM_OUT-1:0]  a_sel_q,   a_sel_d;
    logic [NUM_OUT-1:0]         a_mask_q,  a_mask_d;

    // Stage B: gathered result
    logic                       b_valid_q, b_valid_d;
    logic [DW_DATA*NUM_OUT-1:0] b_data_q,  b_data_d;
    logic [NUM_OUT-1:0]         b_mask_q,  b_mask_d;

    logic                       err_q, err_d;

    logic                       a_en, b_en;
    logic [DW_DATA*NUM_OUT-1:0] gather_data;
    logic [NUM_OUT-1:0]         oob_lane;
    logic                       hit;

    // A stage may load when it is empty or when its content moves on this edge.
    always_comb begin
        b_en     = !b_valid_q || out_ready;
        a_en     = !a_valid_q || b_en;
        in_ready = a_en;
    end

    // Gather: an index matching no element yields zero and, if unmasked, flags out-of-range.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        gather_data = '0;
        oob_lane    = '0;
        hit         = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            hit = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (a_sel_q[k*SEL_IN +: SEL_IN] == SEL_IN'(i)) begin
                    hit = 1'b1;
                    if (a_mask_q[k]) begin
                        gather_data[k*DW_DATA +: DW_DATA] = a_data_q[i*DW_DATA +: DW_DATA];
                    end
                end
            end
            oob_lane[k] = a_mask_q[k] && !hit;
        end
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        a_sel_d   = a_sel_q;
        a_mask_d  = a_mask_q;
        if (a_en) begin
            a_valid_d = in_valid;
            a_data_d  = in_data;
            a_sel_d   = in_sel;
            a_mask_d  = in_mask;
        end
    end

    always_comb begin
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        b_mask_d  = b_mask_q;
        if (b_en) begin
            b_valid_d = a_valid_q;
            b_data_d  = gather_data;
            b_mask_d  = a_mask_q;
        end
    end

    // A new out-of-range entry outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (b_en && a_valid_q && (|oob_lane)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // NOTE: data registers are reset as well because the outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_sel_q   <= '0;
            a_mask_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_mask_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
            a_sel_q   <= a_sel_d;
            a_mask_q  <= a_mask_d;
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
            b_mask_q  <= b_mask_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_data  = b_data_q;
    assign out_mask  = b_mask_q;
    assign err_oob   = err_q;

endmodule

// File: tb/tb_sparse_gather_pipe.sv
// Directed bench for sparse_gather_pipe: default 4-input instance plus a 6-input
// instance that can produce out-of-range indices.
module tb_sparse_gather_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, err_oob, err_clr;
    logic [31:0] in_data;
    logic [3:0]  in_sel;
    logic [1:0]  in_mask, out_mask;
    logic [15:0] out_data;

    logic        in_valid6, in_ready6, out_valid6, out_ready6, err_oob6, err_clr6;
    logic [47:0] in_data6;
    logic [5:0]  in_sel6;
    logic [1:0]  in_mask6, out_mask6;
    logic [15:0] out_data6;

    int checks = 0;
    int errors = 0;

    sparse_gather_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .err_oob(err_oob), .err_clr(err_clr)
    );

    sparse_gather_pipe #(.DW_DATA(8), .NUM_IN(6), .NUM_OUT(2), .SEL_IN(3)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .in_sel(in_sel6), .in_mask(in_mask6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .out_mask(out_mask6), .err_oob(err_oob6), .err_clr(err_clr6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] model4(input logic [31:0] d, input logic [3:0] s,
                                           input logic [1:0] m);
        logic [7:0] e [4];
        logic [7:0] l0, l1;
        for (int i = 0; i < 4; i++) e[i] = d[8*i +: 8];
        l0 = m[0] ? e[s[1:0]] : 8'h00;
        l1 = m[1] ? e[s[3:2]] : 8'h00;
        return {m, l1, l0};
    endfunction

    function automatic logic [31:0] stim_data(input int t);
        logic [7:0] b;
        b = 8'(t);
        return {8'h40 + b, 8'h30 + b, 8'h20 + b, 8'h10 + b};
    endfunction

    function automatic logic [3:0] stim_sel(input int t);
        return {2'(t + 1), 2'(t)};
    endfunction

    function automatic logic [1:0] stim_mask(input int t);
        return (t % 3 == 2) ? 2'b01 : 2'b11;
    endfunction

    // Streams n transfers through the default instance with out_ready low in [stall_lo, stall_hi).
    task automatic run_stream(input string name, input int n, input int stall_lo, input int stall_hi);
        logic [17:0] q[$];
        logic [15:0] prev_data;
        int  sent = 0, recv = 0, first_c = -1, last_c = -1;
        bit  ready_low = 1'b0, prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 100 && recv < n; c++) begin
            in_valid  = (sent < n);
            in_data   = stim_data(sent);
            in_sel    = stim_sel(sent);
            in_mask   = stim_mask(sent);
            out_ready = !(c >= stall_lo && c < stall_hi);
            #1;
            if (in_valid && !in_ready) ready_low = 1'b1;
            if (prev_stall) begin
                check({name, " hold_valid"}, 32'(out_valid), 32'd1);
                check({name, " hold_data"}, 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check({name, " sb_nonempty"}, 32'(q.size()), 32'd1);
                else check({name, " data"}, 32'({out_mask, out_data}), 32'(q.pop_front()));
                recv++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                q.push_back(model4(in_data, in_sel, in_mask));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, " count"}, 32'(recv), 32'(n));
        check({name, " ready_dropped"}, 32'(ready_low), 32'(stall_hi > stall_lo));
        if (stall_hi <= stall_lo) check({name, " consecutive"}, 32'(last_c - first_c + 1), 32'(n));
    endtask

    // One transfer into the 6-input instance; err_clr6 optionally asserted on the stage-B edge.
    task automatic xfer6(input logic [47:0] d, input logic [5:0] s, input logic [1:0] m,
                         input logic clr);
        in_valid6 = 1'b1;
        in_data6  = d;
        in_sel6   = s;
        in_mask6  = m;
        cyc();
        in_valid6 = 1'b0;
        err_clr6  = clr;
        cyc();
        err_clr6  = 1'b0;
    endtask

    localparam logic [47:0] D6 = 48'h66_55_44_33_22_11;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_mask = '0; out_ready = 1'b1; err_clr = 1'b0;
        in_valid6 = 1'b0; in_data6 = '0; in_sel6 = '0; in_mask6 = '0; out_ready6 = 1'b1; err_clr6 = 1'b0;
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_mask", 32'(out_mask), 32'd0);
        check("rst err_oob", 32'(err_oob), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        cyc();

        // Basic gather with duplication-free selection
        in_valid = 1'b1; in_data = 32'h44_33_22_11; in_sel = {2'd3, 2'd0}; in_mask = 2'b11;
        cyc();
        in_valid = 1'b0;
        check("t1 latency", 32'(out_valid), 32'd0);
        cyc();
        check("t1 valid", 32'(out_valid), 32'd1);
        check("t1 data", 32'(out_data), 32'h4411);
        check("t1 mask", 32'(out_mask), 32'h3);
        cyc();
        check("t1 single", 32'(out_valid), 32'd0);

        // Same element on both lanes, lane 1 masked off
        in_valid = 1'b1; in_sel = {2'd2, 2'd2}; in_mask = 2'b01;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t2 valid", 32'(out_valid), 32'd1);
        check("t2 data", 32'(out_data), 32'h0033);
        check("t2 mask", 32'(out_mask), 32'h1);
        cyc();

        run_stream("stream", 8, 0, 0);
        run_stream("stall", 8, 3, 8);
        check("pow2 err_oob", 32'(err_oob), 32'd0);

        // Out-of-range handling on the 6-input instance
        xfer6(D6, {3'd2, 3'd7}, 2'b11, 1'b0);
        check("oob valid", 32'(out_valid6), 32'd1);
        check("oob data", 32'(out_data6), 32'h3300);
        check("oob flag", 32'(err_oob6), 32'd1);
        cyc(); cyc(); cyc();
        check("oob sticky", 32'(err_oob6), 32'd1);
        err_clr6 = 1'b1;
        cyc();
        err_clr6 = 1'b0;
        check("oob clear", 32'(err_oob6), 32'd0);
        xfer6(D6, {3'd2, 3'd7}, 2'b10, 1'b0);
        check("oob masked data", 32'(out_data6), 32'h3300);
        check("oob masked mask", 32'(out_mask6), 32'h2);
        check("oob masked flag", 32'(err_oob6), 32'd0);
        xfer6(D6, {3'd6, 3'd5}, 2'b11, 1'b0);
        check("oob idx6 data", 32'(out_data6), 32'h0066);
        check("oob idx6 flag", 32'(err_oob6), 32'd1);
        xfer6(D6, {3'd2, 3'd7}, 2'b11, 1'b1);
        check("oob set_wins", 32'(err_oob6), 32'd1);

        // Reset with two transfers in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0d_0c_0b_0a; in_sel = {2'd1, 2'd2}; in_mask = 2'b11;
        cyc();
        in_data = 32'h1d_1c_1b_1a;
        cyc();
        in_valid = 1'b0;
        check("inflight valid", 32'(out_valid), 32'd1);
        check("inflight in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_data", 32'(out_data), 32'd0);
        check("midrst out_mask", 32'(out_mask), 32'd0);
        check("midrst err_oob6", 32'(err_oob6), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        cyc(); cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            stale = stale | out_valid;
        end
        check("postrst stale", 32'(stale), 32'd0);
        in_valid = 1'b1; in_data = 32'hd4_c3_b2_a1; in_sel = {2'd1, 2'd3}; in_mask = 2'b11;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("postrst valid", 32'(out_valid), 32'd1);
        check("postrst data", 32'(out_data), 32'hb2d4);
        cyc();
        check("postrst single", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
